// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-pointer target.
package i2c_pkg;

  // Protocol phase of the target; *Ack states cover the ninth clock of a byte.
  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_tgt_state_t;

  // SDA level seen on the ninth clock.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Position of the R/W flag in the address byte (1 = read).
  localparam int unsigned RW_BIT = 0;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one open-drain line, with one-cycle edge flags.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, rise_q, fall_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchroniser; resets to the idle (released) bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after FILT_LEN consecutive samples that differ from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer, exposing a simple register read/write bus.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned AW          = 4,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          scl_oe,
  output logic          sda_oe,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .line_in (scl_in),
    .level   (scl_level),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .line_in (sda_in),
    .level   (sda_level),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [6:0]     shift_q, shift_d;   // previous seven bits; full byte = {shift_q, sda_level}
  logic [6:0]     tx_q, tx_d;         // read bits still to be driven, next one at [6]
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           phase_q, phase_d;   // ack states: second half pending / master ACK seen
  logic           sda_oe_q, sda_oe_d;
  logic           wr_valid_q, wr_valid_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;

  logic       start_cond, stop_cond, last_bit;
  logic [7:0] byte_in;

  assign start_cond = sda_fall & scl_level;
  assign stop_cond  = sda_rise & scl_level;
  assign byte_in    = {shift_q, sda_level};
  assign last_bit   = (bit_cnt_q == 3'd7);

  // Next-state logic: START/STOP take priority over any bit-level activity.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_cond) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      shift_d   = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_cond) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;

        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            phase_d   = 1'b0;
            if (last_bit) begin
              if (state_q == StAddr) begin
                // General call (address 0) is never answered.
                if (byte_in[7:1] == TARGET_ADDR && byte_in[7:1] != 7'd0) begin
                  state_d = StAddrAck;
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = byte_in[AW-1:0];
                state_d = StPtrAck;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + 1'b1;
                state_d    = StWdataAck;
              end
            end
          end
        end

        // Drive ACK from the fall ending bit 8 to the fall ending the ninth clock.
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAddrAck && shift_q[RW_BIT]) begin
                state_d  = StRdata;
                tx_d     = rd_data[6:0];
                sda_oe_d = ~rd_data[7];
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end

        StRdata: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = StRdataAck;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end

        // Pointer advances on either response so it ends one past the last byte read.
        StRdataAck: begin
          if (!phase_q && scl_rise) begin
            ptr_d = ptr_q + 1'b1;
            if (sda_level == I2C_ACK) begin
              phase_d = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end else if (phase_q && scl_fall) begin
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            tx_d      = rd_data[6:0];
            sda_oe_d  = ~rd_data[7];
            state_d   = StRdata;
          end
        end

        StIgnore: sda_oe_d = 1'b0;

        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset releases SDA immediately.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign scl_oe   = 1'b0;
  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;
  assign busy     = (state_q == StAddrAck) || (state_q == StPtr) || (state_q == StPtrAck) ||
                    (state_q == StWdata) || (state_q == StWdataAck) ||
                    (state_q == StRdata) || (state_q == StRdataAck);

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register file, transaction-level model.
module tb_i2c_target_regs;

  localparam int unsigned AW       = 4;
  localparam int unsigned FILT_LEN = 4;
  localparam int          Q        = 12;  // quarter SCL period in clk cycles

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl_drv = 1'b1, sda_drv = 1'b1;
  logic          scl_line, sda_line;
  logic          scl_oe, sda_oe, wr_valid, busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data, rd_data;

  int checks = 0;
  int errors = 0;

  assign scl_line = scl_drv & ~scl_oe;
  assign sda_line = sda_drv & ~sda_oe;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .AW(AW), .FILT_LEN(FILT_LEN)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .scl_in      (scl_line),
    .sda_in      (sda_line),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Local register file served to the target, with one clock of read latency.
  logic [7:0] mem [16];
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [7:0] load_data = '0;
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (wr_valid) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  logic [11:0] wr_log [$];
  always @(negedge clk) if (wr_valid) wr_log.push_back({wr_addr, wr_data});

  // Reference model
  logic [7:0] exp_mem [16];
  int         ptr_m = 0;
  logic [7:0] tx_bytes [$];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic m_stop();
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic m_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; wait_clk(Q);
      scl_drv = 1'b1; wait_clk(2 * Q);
      scl_drv = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    m_bits(b);
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    ack = sda_line; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic m_read(input logic nack, output logic [7:0] b);
    b = '0;
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q);
      scl_drv = 1'b1; wait_clk(Q);
      b[i] = sda_line; wait_clk(Q);
      scl_drv = 1'b0; wait_clk(Q);
    end
    sda_drv = nack; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(2 * Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    load_en = 1'b1; load_addr = 4'(a); load_data = v;
    wait_clk(1);
    load_en = 1'b0;
    exp_mem[a] = v;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) preload(i, 8'($urandom_range(0, 255)));
    preload(7, 8'h11);
    preload(8, 8'h22);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(20);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe got %b exp 0", scl_oe); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b exp 0", wr_valid); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %h exp 0", rd_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    ptr_m = 0;
  endtask

  // Write transaction: pointer p, then all bytes queued in tx_bytes.
  task automatic test_write(input logic [7:0] p);
    logic        ack;
    logic [3:0]  ea;
    logic [11:0] exp_e;
    int          n;
    n = tx_bytes.size();
    wr_log.delete();
    m_start();
    m_write(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b exp 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", busy); end
    m_write(p, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack got %b exp 0", ack); end
    for (int i = 0; i < n; i++) begin
      m_write(tx_bytes[i], ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack[%0d] got %b exp 0", i, ack); end
    end
    m_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got %b exp 0", busy); end
    checks++;
    if (wr_log.size() != n) begin
      errors++; $display("FAIL wr_count got %0d exp %0d", wr_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ea = 4'((p + i) % 16);
        exp_e = {ea, tx_bytes[i]};
        checks++;
        if (wr_log[i] !== exp_e) begin
          errors++; $display("FAIL wr_strobe[%0d] got %h exp %h", i, wr_log[i], exp_e);
        end
      end
    end
    for (int i = 0; i < n; i++) exp_mem[(p + i) % 16] = tx_bytes[i];
    ptr_m = (p + n) % 16;
    checks++; if (rd_addr !== 4'(ptr_m)) begin errors++; $display("FAIL wr_ptr_end got %h exp %h", rd_addr, 4'(ptr_m)); end
  endtask

  // Read n bytes, optionally setting the pointer first via write + repeated START.
  task automatic test_read(input logic use_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] b;
    wr_log.delete();
    if (use_ptr) begin
      m_start();
      m_write(8'hA0, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_waddr_ack got %b exp 0", ack); end
      m_write(p, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_ptr_ack got %b exp 0", ack); end
      ptr_m = p % 16;
    end
    m_start();
    m_write(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_raddr_ack got %b exp 0", ack); end
    for (int i = 0; i < n; i++) begin
      m_read(i == n - 1, b);
      checks++;
      if (b !== exp_mem[(ptr_m + i) % 16]) begin
        errors++; $display("FAIL rd_byte[%0d] got %h exp %h", i, b, exp_mem[(ptr_m + i) % 16]);
      end
    end
    m_stop();
    ptr_m = (ptr_m + n) % 16;
    checks++; if (rd_addr !== 4'(ptr_m)) begin errors++; $display("FAIL rd_ptr_end got %h exp %h", rd_addr, 4'(ptr_m)); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL rd_no_write got %0d exp 0", wr_log.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got %b exp 0", busy); end
  endtask

  task automatic test_mismatch(input logic [7:0] a);
    logic ack;
    wr_log.delete();
    m_start();
    m_write(a, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_nack addr %h got %b exp 1", a, ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got %b exp 0", busy); end
    m_write(8'($urandom_range(0, 255)), ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_data_nack got %b exp 1", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy2 got %b exp 0", busy); end
    m_stop();
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL mm_no_write got %0d exp 0", wr_log.size()); end
    checks++; if (rd_addr !== 4'(ptr_m)) begin errors++; $display("FAIL mm_ptr got %h exp %h", rd_addr, 4'(ptr_m)); end
  endtask

  task automatic test_glitch();
    logic ack;
    // Too short: no START, so the address byte goes unanswered.
    sda_drv = 1'b0; wait_clk(FILT_LEN - 1);
    sda_drv = 1'b1; wait_clk(2 * Q);
    scl_drv = 1'b0; wait_clk(Q);
    m_write(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL glitch_no_start got %b exp 1", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
    m_stop();
    // Exactly FILT_LEN cycles low while SCL high is a valid START.
    sda_drv = 1'b0; wait_clk(FILT_LEN);
    scl_drv = 1'b0; wait_clk(Q);
    m_write(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL glitch_start got %b exp 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy got %b exp 1", busy); end
    m_stop();
  endtask

  task automatic test_reset_mid();
    logic ack;
    wr_log.delete();
    m_start();
    m_bits(8'hA0);
    sda_drv = 1'b1; wait_clk(Q);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rm_ack_driven got %b exp 1", sda_oe); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rm_async_release got %b exp 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
    wait_clk(3);
    rst = 1'b0;
    ptr_m = 0;
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(2 * Q);
    m_start();
    m_write(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_reack got %b exp 0", ack); end
    m_stop();
    checks++; if (rd_addr !== 4'(ptr_m)) begin errors++; $display("FAIL rm_ptr got %h exp %h", rd_addr, 4'(ptr_m)); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL rm_no_write got %0d exp 0", wr_log.size()); end
  endtask

  task automatic test_back_to_back();
    int         op, n;
    logic [6:0] a;
    for (int t = 0; t < 10; t++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          tx_bytes.delete();
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
          test_write(8'($urandom_range(0, 255)));
        end
        1: test_read(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        2: test_read(1'b0, 8'h00, $urandom_range(1, 2));
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == 7'h50) a = 7'h51;
          test_mismatch({a, 1'($urandom_range(0, 1))});
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    tx_bytes = '{8'hA5, 8'h5A};
    test_write(8'h03);
    test_read(1'b1, 8'h07, 2);
    test_mismatch(8'hA2);
    test_mismatch(8'h00);
    tx_bytes = '{8'hAA, 8'hBB};
    test_write(8'h0F);
    test_read(1'b0, 8'h00, 1);
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
